// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-FSM side of the arbiter.
// slave = arbiter view, master = environment (requesters + memory FSM) view.
interface mem_arbiter_if;
  logic        a_req, a_we;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        a_ack, a_err;
  logic        b_req, b_we;
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic        b_ack, b_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read_en, mem_write_en, mem_done;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
           mem_rdata, mem_done,
    output a_rdata, a_ack, a_err, b_rdata, b_ack, b_err,
           mem_addr, mem_wdata, mem_read_en, mem_write_en
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
           mem_rdata, mem_done,
    input  a_rdata, a_ack, a_err, b_rdata, b_ack, b_err,
           mem_addr, mem_wdata, mem_read_en, mem_write_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of the BRAM memory FSM: one access
// outstanding, enables held until done, one-cycle ack back, timeout watchdog.
module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic        gnt_b_q, gnt_b_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [15:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic        a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic        b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic        pick_b;

  // B wins only if A is absent, or both request and A went last.
  assign pick_b = bus.b_req & (~bus.a_req | ~last_b_q);

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    gnt_b_d     = gnt_b_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_ack_d     = 1'b0;
    a_err_d     = 1'b0;
    b_ack_d     = 1'b0;
    b_err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.a_req | bus.b_req) begin
          gnt_b_d     = pick_b;
          last_b_d    = pick_b;
          mem_addr_d  = pick_b ? bus.b_addr  : bus.a_addr;
          mem_wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
          rd_en_d     = ~(pick_b ? bus.b_we : bus.a_we);
          wr_en_d     =   pick_b ? bus.b_we : bus.a_we;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + TO_W'(1);
        if (bus.mem_done) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          state_d = ACK;
          if (gnt_b_q) begin
            b_ack_d = 1'b1;
            if (rd_en_q) b_rdata_d = bus.mem_rdata;
          end else begin
            a_ack_d = 1'b1;
            if (rd_en_q) a_rdata_d = bus.mem_rdata;
          end
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          state_d = ACK;
          if (gnt_b_q) begin
            b_ack_d = 1'b1; b_err_d = 1'b1; b_rdata_d = '0;
          end else begin
            a_ack_d = 1'b1; a_err_d = 1'b1; a_rdata_d = '0;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      gnt_b_q     <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      gnt_b_q     <= gnt_b_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_ack_q     <= a_ack_d;
      a_err_q     <= a_err_d;
      b_ack_q     <= b_ack_d;
      b_err_q     <= b_err_d;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_read_en  = rd_en_q;
  assign bus.mem_write_en = wr_en_q;
  assign bus.a_rdata      = a_rdata_q;
  assign bus.a_ack        = a_ack_q;
  assign bus.a_err        = a_err_q;
  assign bus.b_rdata      = b_rdata_q;
  assign bus.b_ack        = b_ack_q;
  assign bus.b_err        = b_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand sequences for alternation, timeout, mid-access reset and held request.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(15), .TO_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // Standard memory FSM model: done pulses two edges after enables rise.
  logic [15:0] mem [0:255];
  logic        m_done, nodone, inject;
  logic [15:0] m_rdata;
  int          mcnt;
  int          cyc = 0;
  assign bus.mem_done  = m_done | inject;
  assign bus.mem_rdata = m_rdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'h5555;
      m_done <= 1'b0; m_rdata <= 16'h0; mcnt <= 0;
    end else if (!(bus.mem_read_en | bus.mem_write_en)) begin
      m_done <= 1'b0; mcnt <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt == 1 && !nodone) begin
        m_done <= 1'b1;
        if (bus.mem_write_en) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        else                  m_rdata <= mem[bus.mem_addr[7:0]];
      end
    end
  end

  typedef struct {
    logic a_req, a_we; logic [15:0] a_addr, a_wdata;
    logic b_req, b_we; logic [15:0] b_addr, b_wdata;
    logic exp_b, exp_we; logic [15:0] exp_addr, exp_wdata, exp_rdata; logic exp_err;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle_inputs(); tick(); tick(); rst_n = 1;
  endtask

  function automatic logic any_out();
    return |{bus.a_rdata, bus.a_ack, bus.a_err, bus.b_rdata, bus.b_ack, bus.b_err,
             bus.mem_addr, bus.mem_wdata, bus.mem_read_en, bus.mem_write_en};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int k, en_cnt; logic got, first, bad;
    logic [15:0] f_addr, f_wdata; logic f_rd, f_wr;
    bus.a_req = v.a_req; bus.a_we = v.a_we; bus.a_addr = v.a_addr; bus.a_wdata = v.a_wdata;
    bus.b_req = v.b_req; bus.b_we = v.b_we; bus.b_addr = v.b_addr; bus.b_wdata = v.b_wdata;
    en_cnt = 0; got = 0; first = 1; bad = 0; k = 0;
    f_addr = 0; f_wdata = 0; f_rd = 0; f_wr = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.mem_read_en & bus.mem_write_en) bad = 1;
      if (bus.mem_read_en | bus.mem_write_en) begin
        en_cnt++;
        if (bus.mem_read_en != !v.exp_we) bad = 1;
        if (first) begin
          f_addr = bus.mem_addr; f_wdata = bus.mem_wdata;
          f_rd = bus.mem_read_en; f_wr = bus.mem_write_en; first = 0;
        end
      end
      if (bus.a_ack | bus.b_ack) begin got = 1; k = i; break; end
    end
    chk({tag, " ack_seen"}, 32'(got), 1);
    chk({tag, " ack_latency"}, k, 4);
    chk({tag, " en_cycles"}, en_cnt, 3);
    chk({tag, " en_kind"}, {f_rd, f_wr, bad}, {!v.exp_we, v.exp_we, 1'b0});
    chk({tag, " mem_addr"}, 32'(f_addr), 32'(v.exp_addr));
    if (v.exp_we) chk({tag, " mem_wdata"}, 32'(f_wdata), 32'(v.exp_wdata));
    chk({tag, " ack_port"}, {bus.a_ack, bus.b_ack}, {!v.exp_b, v.exp_b});
    chk({tag, " rdata"}, 32'(v.exp_b ? bus.b_rdata : bus.a_rdata), 32'(v.exp_rdata));
    chk({tag, " err"}, 32'(v.exp_b ? bus.b_err : bus.a_err), 32'(v.exp_err));
    idle_inputs();
    tick();
    chk({tag, " ack_one_cycle"}, {bus.a_ack, bus.b_ack}, 0);
  endtask

  vec_t vt[7];
  int ack_cyc[4];
  logic ack_b[4];
  logic [15:0] ack_rd[4];
  int n_ack, bad_en;

  initial begin
    // port A fields, port B fields, expected {port B?, we, addr, wdata, rdata, err}
    vt[0] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0};
    vt[1] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h00FF, 16'h1234, 1, 1, 16'h00FF, 16'h1234, 16'h0000, 0};
    vt[2] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h00FF, 16'h0000, 1, 0, 16'h00FF, 16'h0000, 16'h1234, 0};
    vt[3] = '{1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0020, 16'h0000, 16'h5555, 0};
    vt[4] = '{1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0};
    vt[5] = '{1, 1, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0020, 16'hAAAA, 16'h5555, 0};
    vt[6] = '{1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0020, 16'h0000, 16'hAAAA, 0};

    nodone = 0; inject = 0;
    do_reset();
    chk("reset_outputs", 32'(any_out()), 0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Continuous requests from both ports alternate A,B,A,B, acks 5 cycles apart.
    do_reset();
    bus.a_req = 1; bus.a_addr = 16'h0010; bus.b_req = 1; bus.b_addr = 16'h0020;
    n_ack = 0; bad_en = 0;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      tick();
      if (bus.a_ack | bus.b_ack) begin
        if (bus.mem_read_en | bus.mem_write_en) bad_en++;
        ack_cyc[n_ack] = cyc; ack_b[n_ack] = bus.b_ack;
        ack_rd[n_ack] = bus.b_ack ? bus.b_rdata : bus.a_rdata;
        n_ack++;
      end
    end
    chk("alt_ack_count", n_ack, 4);
    chk("alt_order", {ack_b[0], ack_b[1], ack_b[2], ack_b[3]}, 4'b0101);
    chk("alt_rdata", {ack_rd[0], ack_rd[1]}, {16'hBEEF, 16'h5555});
    for (int i = 1; i < 4; i++) chk($sformatf("alt_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 5);
    chk("alt_en_low_in_ack", bad_en, 0);
    idle_inputs(); tick();

    // Memory never completes: watchdog aborts with err and zeroed rdata.
    nodone = 1;
    bus.a_req = 1; bus.a_addr = 16'h0010;
    n_ack = 0; bad_en = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.mem_read_en) bad_en++;
      if (bus.a_ack | bus.b_ack) begin n_ack = 1; break; end
    end
    chk("to_en_cycles", bad_en, 15);
    chk("to_ack", {bus.a_ack, bus.b_ack}, 2'b10);
    chk("to_err_rdata", {bus.a_err, bus.a_rdata}, {1'b1, 16'h0000});
    idle_inputs(); nodone = 0; tick(); tick();
    inject = 1; tick(); inject = 0;
    n_ack = 0; bad_en = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.a_ack | bus.b_ack) n_ack++;
      if (bus.mem_read_en | bus.mem_write_en) bad_en++;
      tick();
    end
    chk("stale_done_no_ack", n_ack, 0);
    chk("stale_done_no_en", bad_en, 0);

    // Reset while BUSY abandons the access without ack.
    bus.a_req = 1; bus.a_addr = 16'h0020;
    tick();
    chk("rst_busy_en", 32'(bus.mem_read_en), 1);
    rst_n = 0; tick(); rst_n = 1; idle_inputs();
    chk("rst_busy_outputs", 32'(any_out()), 0);
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.a_ack | bus.b_ack | bus.mem_read_en) n_ack++;
    end
    chk("rst_busy_no_ack", n_ack, 0);
    run_vec(vt[0], "post_rst");

    // Held a_req across its ack: one access per 5 cycles, enables low in ACK.
    bus.a_req = 1; bus.a_addr = 16'h0010;
    n_ack = 0; bad_en = 0;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      tick();
      if (bus.a_ack) begin
        if (bus.mem_read_en | bus.mem_write_en) bad_en++;
        ack_cyc[n_ack] = cyc; n_ack++;
      end
    end
    chk("hold_ack_count", n_ack, 4);
    for (int i = 1; i < 4; i++) chk($sformatf("hold_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 5);
    chk("hold_en_low_in_ack", bad_en, 0);
    idle_inputs(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
